// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter sharing one PIPO register load/d_in pair among NREQ requesters.
// Optional feature: define PIPO_ARB_LOCK_EN to add a lock input that re-grants the current owner.
//
// state | meaning
// IDLE  | waiting for any req; arbitrates at each edge
// LOAD  | one cycle, reg_load/ack asserted to the selected requester
// HOLD  | reg_d_in frozen for HOLD_CYCLES cycles before returning to IDLE
module pipo_load_arbiter #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 4,
   parameter int HOLD_CYCLES = 2,
   localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
`ifdef PIPO_ARB_LOCK_EN
   input  logic                  lock,
`endif
   output logic [NREQ-1:0]       ack,
   output logic                  reg_load,
   output logic [WIDTH-1:0]      reg_d_in,
   output logic [OW-1:0]         owner,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

   state_t            state, state_nxt;
   logic [NREQ-1:0]   ack_nxt;
   logic              load_nxt;
   logic [WIDTH-1:0]  d_nxt;
   logic [OW-1:0]     owner_nxt;
   logic              busy_nxt;
   logic [OW-1:0]     ptr, ptr_nxt;
   logic [3:0]        cnt, cnt_nxt;

   logic              found;
   logic              keep_ptr;
   logic [OW-1:0]     sel;
   int                idx;

   // Search starts just above the last grant, so the previous owner ranks lowest.
   always_comb begin
      found    = 1'b0;
      keep_ptr = 1'b0;
      sel      = '0;
      idx      = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = OW'(idx);
         end
      end
`ifdef PIPO_ARB_LOCK_EN
      if (lock && req[owner]) begin
         found    = 1'b1;
         keep_ptr = 1'b1;
         sel      = owner;
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      ack_nxt   = '0;
      load_nxt  = 1'b0;
      d_nxt     = reg_d_in;
      owner_nxt = owner;
      busy_nxt  = busy;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (found) begin
               state_nxt = LOAD;
               d_nxt     = req_data[int'(sel)*WIDTH +: WIDTH];
               ack_nxt   = NREQ'(1) << sel;
               load_nxt  = 1'b1;
               owner_nxt = sel;
               ptr_nxt   = keep_ptr ? ptr : sel;
               busy_nxt  = 1'b1;
            end
         end
         LOAD: begin
            if (HOLD_CYCLES == 0) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_INIT;
            end
         end
         HOLD: begin
            if (cnt == 4'd0) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ack      <= '0;
         reg_load <= 1'b0;
         reg_d_in <= '0;
         owner    <= '0;
         busy     <= 1'b0;
         ptr      <= OW'(NREQ - 1);
         cnt      <= 4'd0;
      end else begin
         state    <= state_nxt;
         ack      <= ack_nxt;
         reg_load <= load_nxt;
         reg_d_in <= d_nxt;
         owner    <= owner_nxt;
         busy     <= busy_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter (NREQ=4, WIDTH=4, HOLD_CYCLES=2) with a model shared register.
module tb_pipo_load_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_data;
`ifdef PIPO_ARB_LOCK_EN
   logic        lock;
`endif
   logic [3:0]  ack;
   logic        reg_load;
   logic [3:0]  reg_d_in;
   logic [1:0]  owner;
   logic        busy;
   logic [3:0]  d_out = 4'h0;

   int vectors     = 0;
   int miscompares = 0;

   pipo_load_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
`ifdef PIPO_ARB_LOCK_EN
      .lock     (lock),
`endif
      .ack      (ack),
      .reg_load (reg_load),
      .reg_d_in (reg_d_in),
      .owner    (owner),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the shared PIPO register; deliberately never reset.
   always @(posedge clk) if (reg_load) d_out <= reg_d_in;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One grant: LOAD cycle checks, then req_after is applied and the HOLD/return cycles are checked.
   task automatic do_grant(input string tag, input int idx, input logic [3:0] data,
                           input logic [3:0] req_after);
      logic [3:0] one;
      one = 4'b0001;
      tick;
      chk({tag, " load"},  reg_load, 1);
      chk({tag, " ack"},   ack, one << idx);
      chk({tag, " d_in"},  reg_d_in, data);
      chk({tag, " owner"}, owner, idx);
      chk({tag, " busy"},  busy, 1);
      req = req_after;
      for (int c = 0; c < 3; c++) begin
         tick;
         chk({tag, " load low"}, reg_load, 0);
         chk({tag, " ack low"},  ack, 0);
         chk({tag, " d_in held"}, reg_d_in, data);
         chk({tag, " busy"}, busy, (c < 2) ? 1 : 0);
         if (c == 0) chk({tag, " d_out"}, d_out, data);
      end
   endtask

   initial begin
`ifdef PIPO_ARB_LOCK_EN
      lock = 1'b0;
`endif
      // Reset with all requests asserted
      rst = 1'b1; req = 4'b1111; req_data = 16'h4321;
      tick; tick;
      chk("rst ack", ack, 0);
      chk("rst load", reg_load, 0);
      chk("rst d_in", reg_d_in, 0);
      chk("rst owner", owner, 0);
      chk("rst busy", busy, 0);

      // Single requester 0 with data A
      rst = 1'b0; req = 4'b0001; req_data = 16'h000A;
      do_grant("single", 0, 4'hA, 4'b0000);
      tick;
      chk("idle load", reg_load, 0);
      chk("idle busy", busy, 0);

      // Fresh reset, all requesting: 0,1,2,3,0 spaced exactly 4 cycles
      rst = 1'b1; tick; rst = 1'b0;
      req = 4'b1111; req_data = 16'h4321;
      do_grant("rr0", 0, 4'h1, 4'b1111);
      do_grant("rr1", 1, 4'h2, 4'b1111);
      do_grant("rr2", 2, 4'h3, 4'b1111);
      do_grant("rr3", 3, 4'h4, 4'b1111);
      do_grant("rr4", 0, 4'h1, 4'b0000);

      // req[2] raised during HOLD is only served after returning to IDLE
      req = 4'b0001;
      tick;
      chk("hold0 ack", ack, 4'b0001);
      req = 4'b0000;
      tick;
      req = 4'b0100;
      chk("hold ack1", ack, 0);
      tick;
      chk("hold ack2", ack, 0);
      tick;
      chk("hold idle ack", ack, 0);
      chk("hold idle load", reg_load, 0);
      do_grant("late2", 2, 4'h3, 4'b0000);

      // A request dropped before any grant is never acked
      req = 4'b1000; req_data = 16'h4321;
      req = 4'b0000;
      tick;
      chk("drop ack", ack, 0);
      chk("drop load", reg_load, 0);

      // Reset during LOAD, then 1010 goes to requester 1 first
      req = 4'b0100;
      tick;
      chk("pre-rst load", reg_load, 1);
      rst = 1'b1; req = 4'b1010;
      tick;
      chk("midload rst load", reg_load, 0);
      chk("midload rst ack", ack, 0);
      chk("midload rst busy", busy, 0);
      chk("midload rst owner", owner, 0);
      chk("midload rst d_in", reg_d_in, 0);
      rst = 1'b0;
      do_grant("post-rst1", 1, 4'h2, 4'b1000);
      do_grant("post-rst3", 3, 4'h4, 4'b0000);

      // Two requesters: alternation, or lock behaviour if enabled
      rst = 1'b1; tick; rst = 1'b0;
      req = 4'b0011;
`ifdef PIPO_ARB_LOCK_EN
      do_grant("lk first", 0, 4'h1, 4'b0011);
      lock = 1'b1;
      do_grant("lk a", 0, 4'h1, 4'b0011);
      do_grant("lk b", 0, 4'h1, 4'b0011);
      do_grant("lk c", 0, 4'h1, 4'b0011);
      lock = 1'b0;
      do_grant("unlk 1", 1, 4'h2, 4'b0011);
      do_grant("unlk 0", 0, 4'h1, 4'b0000);
`else
      do_grant("alt 0", 0, 4'h1, 4'b0011);
      do_grant("alt 1", 1, 4'h2, 4'b0011);
      do_grant("alt 0b", 0, 4'h1, 4'b0011);
      do_grant("alt 1b", 1, 4'h2, 4'b0000);
`endif
      tick;
      chk("end load", reg_load, 0);
      chk("end busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
